fas_peak_finder: RTL and testbench

Parametrised successor of the FAS analysis stage. It takes one complete FFT frame of NPT complex bins in a single beat, computes |X|^2 per bin and returns the index of the strongest bin in a programmable bin range, with a threshold-qualified found flag.
- A double buffer accepts a new frame while the previous one is still being scanned, so back-to-back FFT frames every NPT cycles are sustained.
- It sits directly after the FFT core, consuming fft_valid/fft_d, and drives done/freq to the top level.

---
 rtl/fas_pkg.sv | 20 ++
 rtl/fas_mag_sq.sv | 26 ++
 rtl/fas_peak_finder.sv | 131 +++++++++++++
 tb/tb_fas_peak_finder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared definitions for the FAS peak finder slice.
//   NPT_DEF / DW_DEF : default frame size and component width
//   state_t          : scan controller state
//   bin_lsb()        : bit offset of bin k inside a packed frame
package fas_pkg;

    localparam int unsigned NPT_DEF = 16;
    localparam int unsigned DW_DEF  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Each bin occupies 2*dw bits: real in the upper half, imag in the lower.
    function automatic int unsigned bin_lsb(input int unsigned k, input int unsigned dw);
        return k * 2 * dw;
    endfunction

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational magnitude-squared of one complex bin.
//   re, im : signed two's-complement components (DW bits each)
//   mag    : re*re + im*im as an unsigned MW-bit value
module fas_mag_sq #(
    parameter int unsigned DW = 16,
    parameter int unsigned MW = 2 * DW
) (
    input  logic [DW-1:0] re,
    input  logic [DW-1:0] im,
    output logic [MW-1:0] mag
);

    logic signed [2*DW-1:0] re_x, im_x;
    logic signed [2*DW-1:0] re_sq, im_sq;

    always_comb begin
        re_x  = {{DW{re[DW-1]}}, re};
        im_x  = {{DW{im[DW-1]}}, im};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        // Squares are non-negative, so zero-extension into MW is exact; the
        // sum peaks at 2^(2*DW-1) and never overflows.
        mag   = MW'($unsigned(re_sq)) + MW'($unsigned(im_sq));
    end

endmodule

// File: rtl/fas_peak_finder.sv
// Peak-bin finder over one FFT frame with a double-buffered capture stage.
//   clk, rst         : clock and synchronous active-high reset
//   fft_valid, fft_d : one-beat full-frame input
//   lo_bin, hi_bin   : search range, latched when a frame starts scanning
//   thresh           : minimum peak magnitude for peak_found
//   done             : one-cycle result strobe
//   freq, peak_mag,
//   peak_found       : result, held until the next done
//   busy             : scanning or capture buffer occupied
//   ovf              : one-cycle strobe, incoming frame dropped
module fas_peak_finder
    import fas_pkg::*;
#(
    parameter int unsigned NPT = NPT_DEF,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned IW  = $clog2(NPT),
    parameter int unsigned MW  = 2 * DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fft_valid,
    input  logic [NPT*2*DW-1:0] fft_d,
    input  logic [IW-1:0]       lo_bin,
    input  logic [IW-1:0]       hi_bin,
    input  logic [MW-1:0]       thresh,
    output logic                done,
    output logic [IW-1:0]       freq,
    output logic [MW-1:0]       peak_mag,
    output logic                peak_found,
    output logic                busy,
    output logic                ovf
);

    localparam int unsigned FW = NPT * 2 * DW;
    localparam int unsigned SW = $clog2(FW);

    state_t          state;
    logic [FW-1:0]   cap, work;
    logic            cap_full;
    logic [IW-1:0]   lo_l, hi_l, idx, best_idx;
    logic [MW-1:0]   best_mag;

    logic [SW-1:0]   off;
    logic [2*DW-1:0] bin;
    logic [MW-1:0]   mag;
    logic            illegal, last, xfer, take;
    logic [MW-1:0]   nxt_mag;
    logic [IW-1:0]   nxt_idx;

    fas_mag_sq #(.DW(DW), .MW(MW)) u_mag (
        .re  (bin[2*DW-1:DW]),
        .im  (bin[DW-1:0]),
        .mag (mag)
    );

    always_comb begin
        off     = SW'(bin_lsb(32'(idx), DW));
        bin     = work[off +: 2*DW];
        illegal = (lo_l > hi_l);
        last    = (state == SCAN) && (illegal || (idx == hi_l));
        xfer    = cap_full && ((state == IDLE) || last);
        // Strict compare keeps the lowest index on ties; an illegal range
        // never updates so it reports lo with zero magnitude.
        take    = !illegal && (mag > best_mag);
        nxt_mag = take ? mag : best_mag;
        nxt_idx = take ? idx : best_idx;
    end

    assign busy = (state == SCAN) | cap_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cap        <= '0;
            work       <= '0;
            cap_full   <= 1'b0;
            lo_l       <= '0;
            hi_l       <= '0;
            idx        <= '0;
            best_idx   <= '0;
            best_mag   <= '0;
            done       <= 1'b0;
            freq       <= '0;
            peak_mag   <= '0;
            peak_found <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            ovf  <= 1'b0;

            // Capture side: a frame may land in cap the same cycle cap drains.
            if (fft_valid) begin
                if (!cap_full || xfer) begin
                    cap      <= fft_d;
                    cap_full <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (xfer) begin
                cap_full <= 1'b0;
            end

            if (state == SCAN) begin
                best_mag <= nxt_mag;
                best_idx <= nxt_idx;
                idx      <= idx + 1'b1;
                if (last) begin
                    done       <= 1'b1;
                    freq       <= nxt_idx;
                    peak_mag   <= nxt_mag;
                    peak_found <= !illegal && (nxt_mag >= thresh);
                end
            end

            // Transfer overrides the scan updates above so a new frame can
            // start on the last scan cycle of the previous one with no bubble.
            if (xfer) begin
                work     <= cap;
                lo_l     <= lo_bin;
                hi_l     <= hi_bin;
                idx      <= lo_bin;
                best_idx <= lo_bin;
                best_mag <= '0;
                state    <= SCAN;
            end else if (last) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fas_peak_finder.sv
// Scoreboard bench for fas_peak_finder (NPT=16, DW=16).
module tb_fas_peak_finder;

    logic         clk = 1'b0;
    logic         rst;
    logic         fft_valid;
    logic [511:0] fft_d;
    logic [3:0]   lo_bin, hi_bin;
    logic [31:0]  thresh;
    logic         done;
    logic [3:0]   freq;
    logic [31:0]  peak_mag;
    logic         peak_found;
    logic         busy;
    logic         ovf;

    fas_peak_finder #(.NPT(16), .DW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .fft_valid  (fft_valid),
        .fft_d      (fft_d),
        .lo_bin     (lo_bin),
        .hi_bin     (hi_bin),
        .thresh     (thresh),
        .done       (done),
        .freq       (freq),
        .peak_mag   (peak_mag),
        .peak_found (peak_found),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  freq;
        logic [31:0] mag;
        logic        found;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   ovf_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every result strobe against the scoreboard head.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("freq",       32'(freq),       32'(e.freq));
                check("peak_mag",   peak_mag,        e.mag);
                check("peak_found", 32'(peak_found), 32'(e.found));
                check("done_cycle", cyc,             e.cyc);
            end
        end
        if (ovf) begin
            if (ovf_q.size() == 0) check("unexpected_ovf", 32'(ovf), 32'd0);
            else check("ovf_cycle", cyc, ovf_q.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input logic [3:0] f, input logic [31:0] m, input logic fd, input int c);
        exp_t e;
        e.freq = f; e.mag = m; e.found = fd; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [511:0] f);
        fft_d     = f;
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            tick();
            k++;
        end
        check("idle_reached", 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    function automatic logic [511:0] put_bin(input logic [511:0] f, input int k,
                                             input logic [15:0] re, input logic [15:0] im);
        f[k*32 +: 32] = {re, im};
        return f;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_freq"},  32'(freq),       32'd0);
        check({tag, "_mag"},   peak_mag,        32'd0);
        check({tag, "_found"}, 32'(peak_found), 32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_ovf"},   32'(ovf),        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [511:0] f, fa, fb, fc;
        int c;
        int          bb_bin [8] = '{2, 7, 12, 1, 6, 11, 0, 5};
        logic [31:0] bb_mag [8] = '{32'h10000, 32'h40000, 32'h90000, 32'h100000,
                                    32'h190000, 32'h240000, 32'h310000, 32'h400000};

        rst = 1'b1; fft_valid = 1'b0; fft_d = '0;
        lo_bin = 4'd0; hi_bin = 4'd15; thresh = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_outputs_zero("reset");

        // Single frame, full range.
        f = '0;
        f = put_bin(f, 1, 16'h0400, 16'h0000);
        f = put_bin(f, 15, 16'h0000, 16'h0300);
        expect_done(4'd1, 32'h00100000, 1'b1, cyc + 18);
        drive(f);
        check("busy_after_capture", 32'(busy), 32'd1);
        wait_idle();

        // Tie: lowest index wins.
        f = '0;
        f = put_bin(f, 3, 16'h0100, 16'h0100);
        f = put_bin(f, 9, 16'h0100, 16'h0100);
        expect_done(4'd3, 32'h00020000, 1'b1, cyc + 18);
        drive(f);
        wait_idle();

        // Restricted range and unmet threshold.
        lo_bin = 4'd4; hi_bin = 4'd12; thresh = 32'h00030000;
        expect_done(4'd9, 32'h00020000, 1'b0, cyc + 11);
        drive(f);
        wait_idle();

        // Back-to-back frames every 16 cycles.
        lo_bin = 4'd0; hi_bin = 4'd15; thresh = '0;
        c = cyc;
        for (int i = 0; i < 8; i++) begin
            f = '0;
            f = put_bin(f, bb_bin[i], 16'(16'h0100 * (i + 1)), 16'h0000);
            expect_done(4'(bb_bin[i]), bb_mag[i], 1'b1, c + 18 + 16 * i);
            drive(f);
            repeat (15) tick();
        end
        wait_idle();

        // Overflow: three consecutive frames from IDLE, third dropped.
        fa = put_bin('0, 2,  16'h0200, 16'h0000);
        fb = put_bin('0, 10, 16'h0000, 16'h0100);
        fc = put_bin('0, 5,  16'h0300, 16'h0000);
        c = cyc;
        expect_done(4'd2,  32'h00040000, 1'b1, c + 18);
        expect_done(4'd10, 32'h00010000, 1'b1, c + 34);
        ovf_q.push_back(c + 3);
        fft_d = fa; fft_valid = 1'b1; tick();
        fft_d = fb; tick();
        fft_d = fc; tick();
        fft_valid = 1'b0;
        wait_idle();

        // Reset after five scan cycles aborts the scan.
        drive(put_bin('0, 8, 16'h0500, 16'h0000));
        repeat (6) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_outputs_zero("midscan_reset");
        repeat (20) tick();
        check_outputs_zero("after_abort");

        // Negative extreme bin, threshold exactly equal.
        thresh = 32'h80000000;
        expect_done(4'd6, 32'h80000000, 1'b1, cyc + 18);
        drive(put_bin('0, 6, 16'h8000, 16'h8000));
        wait_idle();

        // Illegal range lo > hi.
        lo_bin = 4'd10; hi_bin = 4'd3; thresh = '0;
        expect_done(4'd10, 32'h0, 1'b0, cyc + 3);
        drive(put_bin('0, 10, 16'h1000, 16'h0000));
        wait_idle();

        // All-zero frame, thresh 0 then 1.
        lo_bin = 4'd5; hi_bin = 4'd7; thresh = '0;
        expect_done(4'd5, 32'h0, 1'b1, cyc + 5);
        drive('0);
        wait_idle();
        thresh = 32'd1;
        expect_done(4'd5, 32'h0, 1'b0, cyc + 5);
        drive('0);
        wait_idle();

        repeat (4) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("ovf_queue_empty",  32'(ovf_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
